sdram_port_arbiter: RTL and testbench

//  4-port round-robin Wishbone arbiter that shares one SDRAM controller bus
//  (or the cache in front of it) between CPU, DMA, video and debug masters.

---
 rtl/fpgalib_arb_pkg.sv | 10 +
 rtl/if_wb.sv | 20 ++
 rtl/rr_select.sv | 19 +
 rtl/sdram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpgalib_arb_pkg.sv
// fpgalib_arb_pkg: shared types and constants for the fpgalib bus arbiters
package fpgalib_arb_pkg;

    localparam int NPORTS = 4;

    typedef enum logic [1:0] {IDLE, OWN, DRAIN, GAP} arb_state_t;

    typedef logic [1:0] port_idx_t;

endpackage

// File: rtl/if_wb.sv
// if_wb: pipelined Wishbone bus, master drives requests, slave returns ack/stall/data
interface if_wb #(
    parameter int AWIDTH = 26,
    parameter int DWIDTH = 32
);

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [DWIDTH/8-1:0]   sel;
    logic [AWIDTH-1:0]     adr;
    logic [DWIDTH-1:0]     dat_m;
    logic [DWIDTH-1:0]     dat_s;
    logic                  ack;
    logic                  stall;

    modport master (output cyc, stb, we, sel, adr, dat_m, input ack, stall, dat_s);
    modport slave  (input cyc, stb, we, sel, adr, dat_m, output ack, stall, dat_s);

endinterface

// File: rtl/rr_select.sv
// rr_select: combinational round-robin picker, searches last+1, last+2, ... (mod NPORTS)
module rr_select
    import fpgalib_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  port_idx_t         last,
    output logic              valid,
    output port_idx_t         idx
);

    // Walk from the farthest candidate inwards so the nearest requester wins.
    always_comb begin
        valid = |req;
        idx   = last;
        for (int i = NPORTS; i >= 1; i--)
            if (req[port_idx_t'(last + i)]) idx = port_idx_t'(last + i);
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: 4-port round-robin Wishbone arbiter with outstanding-request tracking
module sdram_port_arbiter
    import fpgalib_arb_pkg::*;
#(
    parameter int AWIDTH = 26,
    parameter int DWIDTH = 32,
    parameter int OWIDTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    if_wb.slave       in0,
    if_wb.slave       in1,
    if_wb.slave       in2,
    if_wb.slave       in3,
    if_wb.master      out,
    output port_idx_t grant_o,
    output logic      busy_o,
    output logic      proto_err_o
);

    localparam int SW = DWIDTH / 8;
    localparam logic [OWIDTH-1:0] MAXO = '1;

    arb_state_t        r_state;
    arb_state_t        w_next;
    port_idx_t         r_grant;
    logic [OWIDTH-1:0] r_out;
    logic              r_err;

    logic [NPORTS-1:0] w_cyc;
    logic [NPORTS-1:0] w_stb;
    logic [NPORTS-1:0] w_we;
    logic [NPORTS-1:0] w_own;
    logic [SW-1:0]     w_sel [NPORTS];
    logic [AWIDTH-1:0] w_adr [NPORTS];
    logic [DWIDTH-1:0] w_dat [NPORTS];
    logic [OWIDTH-1:0] w_out_nxt;
    logic              w_valid;
    logic              w_full;
    logic              w_live;
    logic              w_drop;
    logic              w_acc;
    logic              w_ack;
    logic              w_err_set;
    port_idx_t         w_idx;

    assign w_cyc    = {in3.cyc, in2.cyc, in1.cyc, in0.cyc};
    assign w_stb    = {in3.stb, in2.stb, in1.stb, in0.stb};
    assign w_we     = {in3.we, in2.we, in1.we, in0.we};
    assign w_sel[0] = in0.sel;
    assign w_sel[1] = in1.sel;
    assign w_sel[2] = in2.sel;
    assign w_sel[3] = in3.sel;
    assign w_adr[0] = in0.adr;
    assign w_adr[1] = in1.adr;
    assign w_adr[2] = in2.adr;
    assign w_adr[3] = in3.adr;
    assign w_dat[0] = in0.dat_m;
    assign w_dat[1] = in1.dat_m;
    assign w_dat[2] = in2.dat_m;
    assign w_dat[3] = in3.dat_m;

    rr_select u_rr (
        .req   (w_cyc),
        .last  (r_grant),
        .valid (w_valid),
        .idx   (w_idx)
    );

    assign w_full = r_out == MAXO;
    assign w_live = r_out != '0;
    assign w_drop = r_state == OWN && !w_cyc[r_grant];

    // cyc stays up while anything is in flight so downstream never sees a torn cycle.
    assign out.cyc   = (r_state == OWN && (w_cyc[r_grant] || w_live)) || r_state == DRAIN;
    assign out.stb   = r_state == OWN && w_cyc[r_grant] && w_stb[r_grant] && !w_full;
    assign out.we    = w_we[r_grant];
    assign out.sel   = w_sel[r_grant];
    assign out.adr   = w_adr[r_grant];
    assign out.dat_m = w_dat[r_grant];

    assign w_acc     = out.stb && !out.stall;
    assign w_ack     = out.ack && (r_state == OWN || r_state == DRAIN);
    assign w_out_nxt = (w_acc && !w_ack) ? r_out + 1'b1 :
                       (w_ack && !w_acc && w_live) ? r_out - 1'b1 : r_out;
    assign w_err_set = (w_ack && !w_acc && !w_live) || (w_drop && w_live);

    // Only an owner still holding cyc sees the bus; everyone else is stalled.
    assign w_own = (r_state == OWN && w_cyc[r_grant]) ? NPORTS'(1) << r_grant : '0;

    assign in0.ack   = w_own[0] && out.ack;
    assign in1.ack   = w_own[1] && out.ack;
    assign in2.ack   = w_own[2] && out.ack;
    assign in3.ack   = w_own[3] && out.ack;
    assign in0.stall = !w_own[0] || out.stall || w_full;
    assign in1.stall = !w_own[1] || out.stall || w_full;
    assign in2.stall = !w_own[2] || out.stall || w_full;
    assign in3.stall = !w_own[3] || out.stall || w_full;
    assign in0.dat_s = w_own[0] ? out.dat_s : '0;
    assign in1.dat_s = w_own[1] ? out.dat_s : '0;
    assign in2.dat_s = w_own[2] ? out.dat_s : '0;
    assign in3.dat_s = w_own[3] ? out.dat_s : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = w_valid ? OWN : IDLE;
            OWN:   w_next = !w_drop ? OWN : (w_live ? DRAIN : GAP);
            DRAIN: w_next = (w_out_nxt == '0) ? GAP : DRAIN;
            GAP:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_grant <= 2'd3;
            r_out   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= w_out_nxt;
            r_err   <= r_err || w_err_set;
            if (r_state == IDLE && w_valid) r_grant <= w_idx;
        end
    end

    assign grant_o     = r_grant;
    assign busy_o      = r_state == OWN || r_state == DRAIN;
    assign proto_err_o = r_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed checks of arbitration, pipelining, drain, limit and reset
module tb_sdram_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    if_wb #(.AWIDTH(26), .DWIDTH(32)) a0(), a1(), a2(), a3(), ao();
    if_wb #(.AWIDTH(26), .DWIDTH(32)) b0(), b1(), b2(), b3(), bo();

    logic [1:0]  grant_a, grant_b;
    logic        busy_a, busy_b, err_a, err_b;
    logic [2:0]  sh = '0;
    logic [31:0] shd [3];
    logic        b_ack = 1'b0;

    sdram_port_arbiter #(.AWIDTH(26), .DWIDTH(32), .OWIDTH(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .in0(a0), .in1(a1), .in2(a2), .in3(a3), .out(ao),
        .grant_o(grant_a), .busy_o(busy_a), .proto_err_o(err_a)
    );

    sdram_port_arbiter #(.AWIDTH(26), .DWIDTH(32), .OWIDTH(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .in0(b0), .in1(b1), .in2(b2), .in3(b3), .out(bo),
        .grant_o(grant_b), .busy_o(busy_b), .proto_err_o(err_b)
    );

    // Downstream stub for dut_a: never stalls, acks each accepted request 3 cycles later.
    assign ao.stall = 1'b0;
    assign ao.ack   = sh[2];
    assign ao.dat_s = shd[2];
    always @(posedge clk) begin
        sh     <= {sh[1:0], ao.cyc && ao.stb && !ao.stall};
        shd[0] <= 32'(ao.adr) ^ 32'hDEAD_0000;
        shd[1] <= shd[0];
        shd[2] <= shd[1];
    end

    assign bo.stall = 1'b0;
    assign bo.ack   = b_ack;
    assign bo.dat_s = 32'h1234_5678;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(int k, logic c, logic s, logic [25:0] ad);
        case (k)
            0: begin a0.cyc = c; a0.stb = s; a0.adr = ad; a0.we = 1'b0; a0.sel = '1; a0.dat_m = '0; end
            1: begin a1.cyc = c; a1.stb = s; a1.adr = ad; a1.we = 1'b0; a1.sel = '1; a1.dat_m = '0; end
            2: begin a2.cyc = c; a2.stb = s; a2.adr = ad; a2.we = 1'b0; a2.sel = '1; a2.dat_m = '0; end
            default: begin a3.cyc = c; a3.stb = s; a3.adr = ad; a3.we = 1'b0; a3.sel = '1; a3.dat_m = '0; end
        endcase
    endtask

    function automatic logic ack_of(int k);
        return k == 0 ? a0.ack : k == 1 ? a1.ack : k == 2 ? a2.ack : a3.ack;
    endfunction

    task automatic wait_busy_a(string tag);
        for (int t = 0; t < 20 && !busy_a; t++) step();
        chk(tag, busy_a, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int g, nack, noth, fwd;
        for (int k = 0; k < 4; k++) set_port(k, 1'b0, 1'b0, '0);
        b0.cyc = 0; b0.stb = 0; b0.we = 0; b0.sel = '1; b0.adr = '0; b0.dat_m = '0;
        b1.cyc = 0; b1.stb = 0; b1.we = 0; b1.sel = '1; b1.adr = '0; b1.dat_m = '0;
        b2.cyc = 0; b2.stb = 0; b2.we = 0; b2.sel = '1; b2.adr = '0; b2.dat_m = '0;
        b3.cyc = 0; b3.stb = 0; b3.we = 0; b3.sel = '1; b3.adr = '0; b3.dat_m = '0;
        repeat (2) step();
        chk("rst_grant", grant_a, 3);
        chk("rst_busy", busy_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_cyc", ao.cyc, 0);
        chk("rst_stb", ao.stb, 0);
        chk("rst_stall0", a0.stall, 1);
        chk("rst_stall3", a3.stall, 1);
        chk("rst_ack1", a1.ack, 0);
        rst = 1'b0;

        // 1: simultaneous in0/in2, in0 first, then in2 after GAP and IDLE
        set_port(0, 1, 0, '0);
        set_port(2, 1, 0, '0);
        #1;
        chk("t1_latency", ao.cyc, 0);
        step();
        chk("t1_grant0", grant_a, 0);
        chk("t1_outcyc", ao.cyc, 1);
        chk("t1_in2_stall", a2.stall, 1);
        set_port(0, 1, 1, 26'h10);
        #1;
        chk("t1_stb", ao.stb, 1);
        chk("t1_adr", ao.adr, 26'h10);
        chk("t1_in0_stall", a0.stall, 0);
        step();
        set_port(0, 1, 0, 26'h10);
        step();
        chk("t1_early_ack", a0.ack, 0);
        step();
        chk("t1_ack", a0.ack, 1);
        chk("t1_dat", a0.dat_s, 32'hDEAD_0010);
        chk("t1_in2_noack", a2.ack, 0);
        step();
        set_port(0, 0, 0, '0);
        #1;
        chk("t1_drop", ao.cyc, 0);
        step();
        chk("t1_gap_cyc", ao.cyc, 0);
        chk("t1_gap_busy", busy_a, 0);
        chk("t1_gap_grant", grant_a, 0);
        step();
        chk("t1_idle_cyc", ao.cyc, 0);
        step();
        chk("t1_grant2", grant_a, 2);
        chk("t1_in2_cyc", ao.cyc, 1);
        set_port(2, 0, 0, '0);
        step();
        step();

        // 2: all four requesting, one read each, release and re-request
        do_reset();
        for (int k = 0; k < 4; k++) set_port(k, 1, 0, '0);
        for (int i = 0; i < 5; i++) begin
            wait_busy_a("t2_busy");
            chk("t2_grant", grant_a, exp_order[i]);
            g = int'(grant_a);
            set_port(g, 1, 1, 26'(32'h200 + i));
            step();
            set_port(g, 1, 0, '0);
            for (int t = 0; t < 10 && !ack_of(g); t++) step();
            chk("t2_ack", ack_of(g), 1);
            step();
            if (i == 4) for (int k = 0; k < 4; k++) set_port(k, 0, 0, '0);
            else set_port(g, 0, 0, '0);
            step();
            if (i < 4) set_port(g, 1, 0, '0);
        end
        step();
        step();
        chk("t2_noerr", err_a, 0);

        // 3: in1 pipelines four requests, downstream latency 3
        set_port(1, 1, 0, '0);
        wait_busy_a("t3_busy");
        chk("t3_grant", grant_a, 1);
        nack = 0;
        noth = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) set_port(1, 1, 1, 26'(32'h100 + c));
            else set_port(1, 1, 0, '0);
            #1;
            if (a1.ack) begin
                chk("t3_dat", a1.dat_s, (32'h100 + nack) ^ 32'hDEAD_0000);
                nack++;
            end
            if (a0.ack || a2.ack || a3.ack) noth++;
            step();
        end
        chk("t3_nack", nack, 4);
        chk("t3_other_acks", noth, 0);
        set_port(1, 0, 0, '0);
        step();
        step();
        chk("t3_busy_end", busy_a, 0);
        chk("t3_noerr", err_a, 0);

        // 4: in3 drops cyc with two requests in flight
        set_port(3, 1, 0, '0);
        wait_busy_a("t4_busy");
        chk("t4_grant", grant_a, 3);
        set_port(3, 1, 1, 26'h300);
        step();
        set_port(3, 1, 1, 26'h301);
        step();
        set_port(3, 0, 0, '0);
        #1;
        chk("t4_hold", ao.cyc, 1);
        step();
        chk("t4_err", err_a, 1);
        chk("t4_drain_busy", busy_a, 1);
        chk("t4_drain_cyc", ao.cyc, 1);
        chk("t4_drain_stb", ao.stb, 0);
        chk("t4_noack_a", a3.ack, 0);
        step();
        chk("t4_drain_cyc2", ao.cyc, 1);
        chk("t4_noack_b", a3.ack, 0);
        step();
        chk("t4_gap_cyc", ao.cyc, 0);
        chk("t4_gap_busy", busy_a, 0);
        step();

        // 6: reset mid-OWN with two outstanding, late acks ignored
        do_reset();
        chk("t6_err_clr", err_a, 0);
        set_port(0, 1, 0, '0);
        wait_busy_a("t6_busy");
        set_port(0, 1, 1, 26'h40);
        step();
        set_port(0, 1, 1, 26'h41);
        step();
        set_port(0, 0, 0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_cyc", ao.cyc, 0);
        chk("t6_busy", busy_a, 0);
        chk("t6_grant", grant_a, 3);
        step();
        chk("t6_late_ack", a0.ack, 0);
        step();
        chk("t6_err", err_a, 0);
        chk("t6_busy2", busy_a, 0);

        // 5: OWIDTH=2 limits in-flight requests to 3
        b0.cyc = 1;
        for (int t = 0; t < 20 && !busy_b; t++) step();
        chk("t5_busy", busy_b, 1);
        chk("t5_grant", grant_b, 0);
        b0.stb = 1;
        fwd = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bo.stb && !bo.stall) fwd++;
            step();
        end
        chk("t5_fwd", fwd, 3);
        #1;
        chk("t5_stall", b0.stall, 1);
        chk("t5_stb_gated", bo.stb, 0);
        b_ack = 1'b1;
        #1;
        chk("t5_ack", b0.ack, 1);
        chk("t5_stall_ack", b0.stall, 1);
        step();
        b_ack = 1'b0;
        #1;
        chk("t5_freed_stall", b0.stall, 0);
        chk("t5_freed_stb", bo.stb, 1);
        step();
        b0.stb = 0;
        b_ack = 1'b1;
        repeat (3) step();
        b_ack = 1'b0;
        b0.cyc = 0;
        step();
        chk("t5_busy_end", busy_b, 0);
        chk("t5_noerr", err_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
